// File: rtl/decode_stage.sv
// Decode/issue stage feeding the ALU: register file, R/I decode, immediate
// sign-extension, RAW/WAW scoreboard and a one-entry issue register.
module decode_stage #(
   parameter int DATA_W   = 32,
   parameter int RF_DEPTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic [31:0]       if_instr,
   input  logic [31:0]       if_pc,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [5:0]        ex_opcode,
   output logic [4:0]        ex_shamt,
   output logic [5:0]        ex_funct,
   output logic [DATA_W-1:0] ex_in1,
   output logic [DATA_W-1:0] ex_in2,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [4:0]        ex_dest,
   output logic              ex_reg_write,
   output logic [31:0]       ex_pc,
   input  logic              wb_we,
   input  logic [4:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] F_ADD    = 6'b100000;
   localparam logic [5:0] F_SUB    = 6'b100010;
   localparam logic [5:0] F_AND    = 6'b100100;
   localparam logic [5:0] F_OR     = 6'b100101;
   localparam logic [5:0] F_SRL    = 6'b000010;
   localparam logic [5:0] F_SLL    = 6'b000000;

   logic [DATA_W-1:0]   rf_reg [RF_DEPTH];
   logic [RF_DEPTH-1:0] pend_reg, pend_next;
   logic [RF_DEPTH-1:0] wb_clr;

   logic              ex_valid_reg, ex_reg_write_reg;
   logic [5:0]        ex_opcode_reg, ex_funct_reg;
   logic [4:0]        ex_shamt_reg, ex_dest_reg;
   logic [DATA_W-1:0] ex_in1_reg, ex_in2_reg, ex_store_data_reg;
   logic [31:0]       ex_pc_reg;

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;

   assign opcode = if_instr[31:26];
   assign rs     = if_instr[25:21];
   assign rt     = if_instr[20:16];
   assign rd     = if_instr[15:11];
   assign shamt  = if_instr[10:6];
   assign funct  = if_instr[5:0];
   assign imm    = if_instr[15:0];

   logic       supported, uses_rt, imm_sel, is_sw, reg_write_dec;
   logic [4:0] dest_dec;

   always_comb begin
      supported = 1'b0;
      uses_rt   = 1'b0;
      imm_sel   = 1'b0;
      is_sw     = 1'b0;
      dest_dec  = 5'd0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               F_ADD, F_SUB, F_AND, F_OR, F_SRL, F_SLL: begin
                  supported = 1'b1;
                  uses_rt   = 1'b1;
                  dest_dec  = rd;
               end
               default: ;
            endcase
         end
         OP_LW: begin
            supported = 1'b1;
            imm_sel   = 1'b1;
            dest_dec  = rt;
         end
         OP_SW: begin
            supported = 1'b1;
            uses_rt   = 1'b1;
            imm_sel   = 1'b1;
            is_sw     = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            supported = 1'b1;
            uses_rt   = 1'b1;
         end
         default: ;
      endcase
   end

   assign reg_write_dec = supported && (dest_dec != 5'd0);

   // Operand read with same-cycle writeback bypass; r0 is hardwired to zero.
   logic [DATA_W-1:0] rs_val, rt_val, imm_ext;
   assign rs_val  = (rs == 5'd0) ? '0 : (wb_we && wb_addr == rs) ? wb_data : rf_reg[rs];
   assign rt_val  = (rt == 5'd0) ? '0 : (wb_we && wb_addr == rt) ? wb_data : rf_reg[rt];
   assign imm_ext = {{(DATA_W-16){imm[15]}}, imm};

   logic hazard, accept;
   assign hazard = if_valid && supported &&
                   ((pend_reg[rs] && !wb_clr[rs]) ||
                    (uses_rt && pend_reg[rt] && !wb_clr[rt]) ||
                    (reg_write_dec && pend_reg[dest_dec] && !wb_clr[dest_dec]));

   assign if_ready = !rst && !flush && !hazard && (!ex_valid_reg || ex_ready);
   assign accept   = if_valid && if_ready;

   // Per-register pending bit: set on issue wins over writeback/flush clears.
   genvar gi;
   generate
      for (gi = 0; gi < RF_DEPTH; gi++) begin : g_sb
         assign wb_clr[gi] = wb_we && (wb_addr == 5'(gi));
         if (gi == 0) begin : g_r0
            assign pend_next[gi] = 1'b0;
         end else begin : g_rn
            logic set_bit, kill_bit;
            assign set_bit  = accept && reg_write_dec && (dest_dec == 5'(gi));
            assign kill_bit = flush && ex_valid_reg && ex_reg_write_reg && (ex_dest_reg == 5'(gi));
            assign pend_next[gi] = set_bit | (pend_reg[gi] & ~wb_clr[gi] & ~kill_bit);
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RF_DEPTH; i++) rf_reg[i] <= '0;
      end else if (wb_we && wb_addr != 5'd0) begin
         rf_reg[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) pend_reg <= '0;
      else     pend_reg <= pend_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_reg      <= 1'b0;
         ex_reg_write_reg  <= 1'b0;
         ex_opcode_reg     <= '0;
         ex_funct_reg      <= '0;
         ex_shamt_reg      <= '0;
         ex_dest_reg       <= '0;
         ex_in1_reg        <= '0;
         ex_in2_reg        <= '0;
         ex_store_data_reg <= '0;
         ex_pc_reg         <= '0;
      end else if (accept) begin
         // Unsupported encodings are consumed but never become valid.
         ex_valid_reg      <= supported;
         ex_reg_write_reg  <= reg_write_dec;
         ex_opcode_reg     <= opcode;
         ex_funct_reg      <= funct;
         ex_shamt_reg      <= shamt;
         ex_dest_reg       <= dest_dec;
         ex_in1_reg        <= rs_val;
         ex_in2_reg        <= imm_sel ? imm_ext : rt_val;
         ex_store_data_reg <= is_sw ? rt_val : '0;
         ex_pc_reg         <= if_pc;
      end else if (flush || ex_ready) begin
         ex_valid_reg <= 1'b0;
      end
   end

   assign ex_valid      = ex_valid_reg;
   assign ex_reg_write  = ex_reg_write_reg;
   assign ex_opcode     = ex_opcode_reg;
   assign ex_funct      = ex_funct_reg;
   assign ex_shamt      = ex_shamt_reg;
   assign ex_dest       = ex_dest_reg;
   assign ex_in1        = ex_in1_reg;
   assign ex_in2        = ex_in2_reg;
   assign ex_store_data = ex_store_data_reg;
   assign ex_pc         = ex_pc_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: issue, RAW stall/bypass, backpressure,
// r0 handling, flush, unsupported drop and mid-stall reset.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst, if_valid, ex_ready, wb_we, flush;
   logic [31:0] if_instr, if_pc, wb_data;
   logic [4:0]  wb_addr;
   logic        if_ready, ex_valid, ex_reg_write;
   logic [5:0]  ex_opcode, ex_funct;
   logic [4:0]  ex_shamt, ex_dest;
   logic [31:0] ex_in1, ex_in2, ex_store_data, ex_pc;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
      .ex_shamt(ex_shamt), .ex_funct(ex_funct), .ex_in1(ex_in1), .ex_in2(ex_in2),
      .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
      .ex_pc(ex_pc), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
      wb_we = 1'b1; wb_addr = a; wb_data = d;
      $display("wb   r%0d <= 0x%08h", a, d);
      tick();
      wb_we = 1'b0;
   endtask

   // Presents one instruction, requires it to be accepted this cycle.
   task automatic issue(input string tag, input logic [31:0] instr, input logic [31:0] pc);
      if_valid = 1'b1; if_instr = instr; if_pc = pc;
      $display("tx   %s pc=0x%08h instr=0x%08h", tag, pc, instr);
      settle();
      chk({tag, "_rdy"}, {31'd0, if_ready}, 32'd1);
      tick();
      if_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; if_valid = 1'b0; ex_ready = 1'b1; wb_we = 1'b0; flush = 1'b0;
      if_instr = '0; if_pc = '0; wb_addr = '0; wb_data = '0;
      tick(); tick();
      chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
      chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst_ex_in1",   ex_in1, 32'd0);
      chk("rst_ex_pc",    ex_pc,  32'd0);
      rst = 1'b0;
      settle();
      chk("idle_if_ready", {31'd0, if_ready}, 32'd1);
      tick();

      wb_write(5'd1, 32'd5);
      wb_write(5'd2, 32'd7);

      // ADD r3,r1,r2 held in the issue register
      ex_ready = 1'b0;
      issue("add_r3", 32'h0022_1820, 32'h100);
      chk("add_valid", {31'd0, ex_valid}, 32'd1);
      chk("add_in1",   ex_in1, 32'd5);
      chk("add_in2",   ex_in2, 32'd7);
      chk("add_dest",  {27'd0, ex_dest}, 32'd3);
      chk("add_rw",    {31'd0, ex_reg_write}, 32'd1);
      chk("add_funct", {26'd0, ex_funct}, 32'h20);
      chk("add_pc",    ex_pc, 32'h100);
      // OR r8,r3,r0 must see r3 pending
      if_valid = 1'b1; if_instr = 32'h0060_4025; ex_ready = 1'b1;
      settle();
      chk("r3_pending", {31'd0, if_ready}, 32'd0);
      if_valid = 1'b0; ex_ready = 1'b0;

      // flush squashes ADD r3 and releases r3
      flush = 1'b1;
      $display("tx   flush");
      tick();
      flush = 1'b0;
      chk("flush_valid", {31'd0, ex_valid}, 32'd0);
      ex_ready = 1'b1;
      issue("or_r8", 32'h0060_4025, 32'h104);
      chk("or_r8_valid", {31'd0, ex_valid}, 32'd1);
      chk("or_r8_in1",   ex_in1, 32'd0);

      // LW r4,-4(r1) then dependent ADD r5,r4,r1
      issue("lw_r4", 32'h8C24_FFFC, 32'h108);
      chk("lw_in1",    ex_in1, 32'd5);
      chk("lw_in2",    ex_in2, 32'hFFFF_FFFC);
      chk("lw_dest",   {27'd0, ex_dest}, 32'd4);
      chk("lw_opcode", {26'd0, ex_opcode}, 32'h23);
      if_valid = 1'b1; if_instr = 32'h0081_2820; if_pc = 32'h10C;
      $display("tx   add_r5 pc=0x%08h instr=0x%08h (stall)", if_pc, if_instr);
      settle();
      chk("raw_stall", {31'd0, if_ready}, 32'd0);
      tick();
      chk("raw_bubble", {31'd0, ex_valid}, 32'd0);
      chk("raw_stall2", {31'd0, if_ready}, 32'd0);
      wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'd9;
      settle();
      chk("raw_release", {31'd0, if_ready}, 32'd1);
      tick();
      wb_we = 1'b0; if_valid = 1'b0;
      chk("add_r5_valid", {31'd0, ex_valid}, 32'd1);
      chk("add_r5_in1",   ex_in1, 32'd9);
      chk("add_r5_in2",   ex_in2, 32'd5);

      // backpressure for 3 cycles with SUB r9,r1,r2 waiting
      ex_ready = 1'b0;
      if_valid = 1'b1; if_instr = 32'h0022_4822; if_pc = 32'h110;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("bp_if_ready", {31'd0, if_ready}, 32'd0);
         chk("bp_valid",    {31'd0, ex_valid}, 32'd1);
         chk("bp_dest",     {27'd0, ex_dest}, 32'd5);
         chk("bp_in1",      ex_in1, 32'd9);
         tick();
      end
      ex_ready = 1'b1;
      settle();
      chk("bp_release", {31'd0, if_ready}, 32'd1);
      tick();
      chk("sub_dest", {27'd0, ex_dest}, 32'd9);
      chk("sub_in1",  ex_in1, 32'd5);
      chk("sub_in2",  ex_in2, 32'd7);
      // SLL r10,r2,3 back-to-back
      if_instr = 32'h0002_50C0; if_pc = 32'h114;
      settle();
      chk("b2b_rdy", {31'd0, if_ready}, 32'd1);
      tick();
      if_valid = 1'b0;
      chk("sll_valid", {31'd0, ex_valid}, 32'd1);
      chk("sll_dest",  {27'd0, ex_dest}, 32'd10);
      chk("sll_shamt", {27'd0, ex_shamt}, 32'd3);
      chk("sll_in2",   ex_in2, 32'd7);

      // r0 writes ignored, r0 destination never pending
      wb_write(5'd0, 32'h0000_FFFF);
      issue("or_r6", 32'h0000_3025, 32'h118);
      chk("r0_in1", ex_in1, 32'd0);
      chk("r0_in2", ex_in2, 32'd0);
      issue("add_r0", 32'h0022_0020, 32'h11C);
      chk("r0_rw",   {31'd0, ex_reg_write}, 32'd0);
      chk("r0_dest", {27'd0, ex_dest}, 32'd0);
      issue("or_r11", 32'h0000_5825, 32'h120);

      // SW r2,8(r1)
      issue("sw", 32'hAC22_0008, 32'h124);
      chk("sw_in2",   ex_in2, 32'd8);
      chk("sw_store", ex_store_data, 32'd7);
      chk("sw_rw",    {31'd0, ex_reg_write}, 32'd0);

      // unsupported funct 0x2A is consumed and dropped
      issue("unsup", 32'h0022_602A, 32'h128);
      chk("unsup_valid", {31'd0, ex_valid}, 32'd0);
      if_valid = 1'b1; if_instr = 32'h0180_6825;
      settle();
      chk("unsup_no_pend", {31'd0, if_ready}, 32'd1);
      if_valid = 1'b0;

      // reset during a pending stall
      issue("lw_r4b", 32'h8C24_0000, 32'h12C);
      if_valid = 1'b1; if_instr = 32'h0081_2820; if_pc = 32'h130;
      settle();
      chk("pre_rst_stall", {31'd0, if_ready}, 32'd0);
      rst = 1'b1;
      $display("tx   reset");
      settle();
      chk("rst2_if_ready", {31'd0, if_ready}, 32'd0);
      tick();
      chk("rst2_valid",  {31'd0, ex_valid}, 32'd0);
      chk("rst2_in1",    ex_in1, 32'd0);
      chk("rst2_in2",    ex_in2, 32'd0);
      chk("rst2_dest",   {27'd0, ex_dest}, 32'd0);
      chk("rst2_rw",     {31'd0, ex_reg_write}, 32'd0);
      chk("rst2_pc",     ex_pc, 32'd0);
      chk("rst2_opcode", {26'd0, ex_opcode}, 32'd0);
      rst = 1'b0;
      settle();
      chk("post_rst_no_pend", {31'd0, if_ready}, 32'd1);
      tick();
      if_valid = 1'b0;
      chk("post_rst_valid", {31'd0, ex_valid}, 32'd1);
      chk("post_rst_in1",   ex_in1, 32'd0);
      chk("post_rst_in2",   ex_in2, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
